// File: rtl/shiftdist_pipe.sv
// shiftdist_pipe: two-stage normalisation shift ahead of the rounder.
// Stage 1 selects the shift distance, stage 2 applies it to the significand.
module shiftdist_pipe #(
  parameter int EW     = 13,
  parameter int LZW    = 6,
  parameter int FW     = 53,
  parameter int EMAX_S = 127,
  parameter int EMAX_D = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] er,
  input  logic [LZW-1:0] lz,
  input  logic          db,
  input  logic          tiny,
  input  logic          unf_en,
  input  logic [FW-1:0] fin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [EW-1:0] sh,
  output logic [EW-1:0] eout,
  output logic [FW-1:0] fout,
  output logic          sticky,
  output logic          sat
);
  localparam int MW = $clog2(FW + 3);
  localparam logic [EW-1:0] RMAX = EW'(FW + 1);
  localparam logic [EW-1:0] LMAX = EW'(FW);
  localparam logic [MW-1:0] MSAT = MW'(FW + 2);
  localparam logic [MW-1:0] MFW  = MW'(FW);

  typedef struct packed {
    logic [EW-1:0] sh;
    logic          rt;
    logic [MW-1:0] mag;
    logic [EW-1:0] er;
    logic [FW-1:0] fin;
  } s1_t;

  logic v1, v2, ld1, ld2;
  s1_t s1, s1_d;
  logic [EW-1:0] bias, neg;
  logic [FW-1:0] mask, fout_d;
  logic sticky_d, sat_d;

  assign ld2 = ~v2 | out_ready;
  assign ld1 = ~v1 | ld2;
  assign in_ready = ld1;
  assign out_valid = v2;

  always_comb begin
    bias = db ? EW'(EMAX_D) : EW'(EMAX_S);
    s1_d = '0;
    s1_d.er = er;
    s1_d.fin = fin;
    if (tiny & ~unf_en)
      s1_d.sh = er + bias;
    else
      s1_d.sh = {{(EW-LZW){1'b0}}, lz};
    s1_d.rt = s1_d.sh[EW-1];
    neg = -s1_d.sh;
    if (s1_d.rt)
      s1_d.mag = (neg > RMAX) ? MSAT : neg[MW-1:0];
    else
      s1_d.mag = (s1_d.sh > LMAX) ? MFW : s1_d.sh[MW-1:0];
  end

  // Right magnitudes past FW+1 arrive clamped to FW+2: saturation.
  always_comb begin
    mask = ~({FW{1'b1}} << s1.mag);
    fout_d = '0;
    sticky_d = 1'b0;
    sat_d = 1'b0;
    if (!s1.rt) begin
      fout_d = s1.fin << s1.mag;
    end else if (s1.mag == MSAT) begin
      sticky_d = |s1.fin;
      sat_d = 1'b1;
    end else begin
      fout_d = s1.fin >> s1.mag;
      sticky_d = |(s1.fin & mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      s1 <= '0;
      sh <= '0;
      eout <= '0;
      fout <= '0;
      sticky <= 1'b0;
      sat <= 1'b0;
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        s1 <= s1_d;
      end
      if (ld2) begin
        v2 <= v1;
        sh <= s1.sh;
        eout <= s1.er - s1.sh;
        fout <= fout_d;
        sticky <= sticky_d;
        sat <= sat_d;
      end
    end
  end

endmodule

// File: tb/tb_shiftdist_pipe.sv
// tb_shiftdist_pipe: scoreboard bench for shiftdist_pipe.
// Directed vectors, backpressure, reset mid-flight and random traffic.
module tb_shiftdist_pipe;
  typedef struct packed {
    logic [12:0] er;
    logic [5:0]  lz;
    logic        db;
    logic        tiny;
    logic        unf_en;
    logic [52:0] fin;
  } op_t;

  typedef struct packed {
    logic [12:0] sh;
    logic [12:0] eout;
    logic [52:0] fout;
    logic        sticky;
    logic        sat;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [12:0] er = '0;
  logic [5:0] lz = '0;
  logic db = 1'b0;
  logic tiny = 1'b0;
  logic unf_en = 1'b0;
  logic [52:0] fin = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [12:0] sh;
  logic [12:0] eout;
  logic [52:0] fout;
  logic sticky;
  logic sat;

  res_t q[$];
  int errors = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;

  shiftdist_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .er(er), .lz(lz), .db(db), .tiny(tiny),
    .unf_en(unf_en), .fin(fin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sh(sh), .eout(eout), .fout(fout),
    .sticky(sticky), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic res_t model(op_t o);
    res_t r;
    logic [12:0] s;
    logic [63:0] f;
    int d, m;
    f = 64'(o.fin);
    if (o.tiny && !o.unf_en)
      s = o.er + (o.db ? 13'd1023 : 13'd127);
    else
      s = {7'd0, o.lz};
    d = int'($signed(s));
    r = '0;
    r.sh = s;
    r.eout = o.er - s;
    if (d >= 0) begin
      if (d < 53) r.fout = 53'(f << d);
    end else begin
      m = -d;
      if (m > 54) begin
        r.sticky = |o.fin;
        r.sat = 1'b1;
      end else begin
        r.fout = 53'(f >> m);
        for (int i = 0; i < m && i < 53; i++)
          if (o.fin[i]) r.sticky = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic res_t got();
    return {sh, eout, fout, sticky, sat};
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    int b;
    o.db = 1'($urandom);
    o.tiny = ($urandom_range(0, 3) != 0);
    o.unf_en = ($urandom_range(0, 3) == 0);
    o.lz = 6'($urandom);
    o.fin = 53'({$urandom(), $urandom()});
    b = o.db ? 1023 : 127;
    case ($urandom_range(0, 2))
      0: o.er = 13'($urandom);
      1: o.er = 13'(-b - int'($urandom_range(0, 60)));
      default: o.er = 13'($urandom_range(0, 100));
    endcase
    return o;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for the sampling edge and retires any result leaving the unit.
  task automatic step();
    res_t e, g;
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      g = got();
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra: got %h, expected no output", g);
      end else begin
        e = q.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL sb_result: got sh=%h eout=%h fout=%h st=%b sat=%b, expected sh=%h eout=%h fout=%h st=%b sat=%b",
                   g.sh, g.eout, g.fout, g.sticky, g.sat,
                   e.sh, e.eout, e.fout, e.sticky, e.sat);
        end
      end
    end
  endtask

  task automatic drive(op_t o);
    er = o.er;
    lz = o.lz;
    db = o.db;
    tiny = o.tiny;
    unf_en = o.unf_en;
    fin = o.fin;
  endtask

  task automatic send(op_t o, res_t e);
    bit acc;
    acc = 1'b0;
    drive(o);
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (in_ready) begin
        q.push_back(e);
        acc = 1'b1;
        break;
      end
      cyc();
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    cyc();
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      if (q.size() == 0) break;
      step();
      cyc();
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results missing, required 0", q.size());
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags: out_valid=%b in_ready=%b, required 0 1",
               out_valid, in_ready);
    end
    checks++;
    if (got() !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h, required 0", got());
    end
    cyc();
    cyc();
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_directed();
    op_t dops[10];
    res_t dexp[10];
    dops[0] = '{13'd100, 6'd3, 1'b0, 1'b0, 1'b0, 53'h2_0000_0000_0000};
    dexp[0] = '{13'd3, 13'd97, 53'h10_0000_0000_0000, 1'b0, 1'b0};
    dops[1] = '{13'h1F7E, 6'd7, 1'b0, 1'b1, 1'b0, 53'h10_0000_0000_0005};
    dexp[1] = '{13'h1FFD, 13'h1F81, 53'h2_0000_0000_0000, 1'b1, 1'b0};
    dops[2] = '{13'h1B50, 6'd0, 1'b1, 1'b1, 1'b0, 53'h1};
    dexp[2] = '{13'h1F4F, 13'h1C01, 53'h0, 1'b1, 1'b1};
    dops[3] = '{13'd2, 6'd5, 1'b0, 1'b1, 1'b1, 53'h1F};
    dexp[3] = '{13'd5, 13'h1FFD, 53'h3E0, 1'b0, 1'b0};
    dops[4] = '{13'h1F4B, 6'd0, 1'b0, 1'b1, 1'b0, 53'h1_0000_0000_0001};
    dexp[4] = '{13'h1FCA, 13'h1F81, 53'h0, 1'b1, 1'b0};
    dops[5] = '{13'h1F4A, 6'd0, 1'b0, 1'b1, 1'b0, 53'h1};
    dexp[5] = '{13'h1FC9, 13'h1F81, 53'h0, 1'b1, 1'b1};
    dops[6] = '{13'd0, 6'd60, 1'b0, 1'b0, 1'b0, 53'h1F_FFFF_FFFF_FFFF};
    dexp[6] = '{13'd60, 13'h1FC4, 53'h0, 1'b0, 1'b0};
    dops[7] = '{13'h1F80, 6'd0, 1'b0, 1'b1, 1'b0, 53'h4};
    dexp[7] = '{13'h1FFF, 13'h1F81, 53'h2, 1'b0, 1'b0};
    dops[8] = '{13'd60, 6'd52, 1'b0, 1'b0, 1'b0, 53'h1};
    dexp[8] = '{13'd52, 13'd8, 53'h10_0000_0000_0000, 1'b0, 1'b0};
    dops[9] = '{13'h1F4C, 6'd0, 1'b0, 1'b1, 1'b0, 53'h10_0000_0000_0000};
    dexp[9] = '{13'h1FCB, 13'h1F81, 53'h0, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(dops[k]);
      in_valid = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_accept: in_ready=%b, required 1", k, in_ready);
      end
      q.push_back(dexp[k]);
      cyc();
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early: out_valid=%b, required 0", k, out_valid);
      end
      cyc();
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_latency: out_valid=%b, required 1", k, out_valid);
      end
      cyc();
    end
    drain();
  endtask

  task automatic test_backpressure();
    op_t ops[4];
    res_t snap;
    for (int k = 0; k < 4; k++) ops[k] = rnd_op();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(ops[k]);
      in_valid = 1'b1;
      step();
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL bp_accept%0d: in_ready=%b, required 1", k, in_ready);
      end
      q.push_back(model(ops[k]));
      cyc();
    end
    drive(ops[2]);
    step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b out_valid=%b, required 0 1",
               in_ready, out_valid);
    end
    snap = got();
    for (int s = 0; s < 3; s++) begin
      cyc();
      step();
      checks++;
      if (in_ready !== 1'b0 || got() !== snap) begin
        errors++;
        $display("FAIL bp_hold%0d: in_ready=%b out=%h, required 0 %h",
                 s, in_ready, got(), snap);
      end
    end
    cyc();
    out_ready = 1'b1;
    for (int k = 2; k < 4; k++) begin
      drive(ops[k]);
      step();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_release%0d: in_ready=%b out_valid=%b, required 1 1",
                 k, in_ready, out_valid);
      end
      q.push_back(model(ops[k]));
      cyc();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_stream%0d: out_valid=%b, required 1", k, out_valid);
      end
      cyc();
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_empty: out_valid=%b pending=%0d, required 0 0",
               out_valid, q.size());
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    op_t o;
    out_ready = 1'b1;
    rnd_ready = 1'b0;
    o = '{13'd100, 6'd3, 1'b0, 1'b0, 1'b0, 53'h2_0000_0000_0000};
    send(o, model(o));
    o = rnd_op();
    send(o, model(o));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || got() !== '0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b in_ready=%b out=%h, required 0 1 0",
               out_valid, in_ready, got());
    end
    q.delete();
    cyc();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale%0d: out_valid=%b, required 0", k, out_valid);
      end
      cyc();
    end
    o = '{13'h1F7E, 6'd7, 1'b0, 1'b1, 1'b0, 53'h10_0000_0000_0005};
    drive(o);
    in_valid = 1'b1;
    step();
    q.push_back('{13'h1FFD, 13'h1F81, 53'h2_0000_0000_0000, 1'b1, 1'b0});
    cyc();
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_early: out_valid=%b, required 0", out_valid);
    end
    cyc();
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_latency: out_valid=%b, required 1", out_valid);
    end
    cyc();
    drain();
  endtask

  task automatic test_random();
    op_t o;
    rnd_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      o = rnd_op();
      send(o, model(o));
      if ($urandom_range(0, 4) == 0) begin
        step();
        cyc();
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_ready = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
